// File: rtl/match_controller.sv
// Penalty shoot-out game-flow controller: sequences START -> SHOOTER/KEEPER
// rounds -> WINNER/LOOSER, keeps both scores and holds each shot result on
// screen for RESULT_HOLD cycles before deciding the next round.
module match_controller #(
  parameter int ROUNDS      = 10,
  parameter int RESULT_HOLD = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode_in,
  input  logic       shot_valid,
  input  logic       shot_goal,
  input  logic       restart,
  output logic [2:0] game_state,
  output logic       game_mode,
  output logic [3:0] round_counter,
  output logic [2:0] score,
  output logic [2:0] opp_score,
  output logic       is_scored
);

  localparam int HW = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
  localparam logic [4:0] HALF = 5'(ROUNDS / 2);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_KEEPER  = 3'd1,
    ST_SHOOTER = 3'd2,
    ST_WINNER  = 3'd3,
    ST_LOOSER  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          hold, hold_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          mode_nxt;
  logic [3:0]    rc_nxt;
  logic [2:0]    score_nxt, opp_nxt;
  logic          scored_nxt;

  logic [4:0] rc5, p_rem, o_rem;
  logic       win, lose, hold_done;

  // Remaining shots per side: the player shoots on odd-numbered rounds.
  always_comb begin
    rc5       = {1'b0, round_counter};
    p_rem     = HALF - ((rc5 + 5'd1) >> 1);
    o_rem     = HALF - (rc5 >> 1);
    win       = {2'b0, score} > ({2'b0, opp_score} + o_rem);
    lose      = {2'b0, opp_score} >= ({2'b0, score} + p_rem);
    hold_done = hold && (hold_cnt == '0);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_START;
      game_mode     <= 1'b1;
      round_counter <= '0;
      score         <= '0;
      opp_score     <= '0;
      is_scored     <= 1'b0;
      hold          <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      game_mode     <= mode_nxt;
      round_counter <= rc_nxt;
      score         <= score_nxt;
      opp_score     <= opp_nxt;
      is_scored     <= scored_nxt;
      hold          <= hold_nxt;
      hold_cnt      <= hold_cnt_nxt;
    end
  end

  // Next-state: start, restart abort, end-of-hold decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_START: if (start) state_nxt = ST_SHOOTER;
      ST_SHOOTER, ST_KEEPER: begin
        if (restart)        state_nxt = ST_START;
        else if (hold_done) begin
          if (win)                     state_nxt = ST_WINNER;
          else if (lose)               state_nxt = ST_LOOSER;
          else if (state == ST_SHOOTER) state_nxt = ST_KEEPER;
          else                         state_nxt = ST_SHOOTER;
        end
      end
      ST_WINNER, ST_LOOSER: if (restart) state_nxt = ST_START;
      default: state_nxt = ST_START;
    endcase
  end

  // Datapath next values: scoring, hold timer, clearing on start/restart.
  always_comb begin
    mode_nxt     = game_mode;
    rc_nxt       = round_counter;
    score_nxt    = score;
    opp_nxt      = opp_score;
    scored_nxt   = is_scored;
    hold_nxt     = hold;
    hold_cnt_nxt = hold_cnt;
    if ((state == ST_START && start) ||
        (state != ST_START && restart)) begin
      if (state == ST_START) mode_nxt = mode_in;
      rc_nxt       = '0;
      score_nxt    = '0;
      opp_nxt      = '0;
      scored_nxt   = 1'b0;
      hold_nxt     = 1'b0;
      hold_cnt_nxt = '0;
    end else if (state == ST_SHOOTER || state == ST_KEEPER) begin
      if (hold) begin
        if (hold_done) begin
          hold_nxt   = 1'b0;
          scored_nxt = 1'b0;
        end else begin
          hold_cnt_nxt = hold_cnt - HW'(1);
        end
      end else if (shot_valid) begin
        rc_nxt       = round_counter + 4'd1;
        scored_nxt   = shot_goal;
        hold_nxt     = 1'b1;
        hold_cnt_nxt = HW'(RESULT_HOLD - 1);
        if (shot_goal) begin
          if (state == ST_SHOOTER) score_nxt = score + 3'd1;
          else                     opp_nxt   = opp_score + 3'd1;
        end
      end
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_match_controller.sv
// Randomized scoreboard bench for match_controller with a shot-history
// reference model.
module tb_match_controller;

  localparam int ROUNDS = 10;
  localparam int HOLD   = 4;
  localparam int HALF   = ROUNDS / 2;
  localparam int NCYC   = 20000;

  logic       clk = 1'b1;
  logic       rst, start, mode_in, shot_valid, shot_goal, restart;
  logic [2:0] game_state, score, opp_score;
  logic       game_mode, is_scored;
  logic [3:0] round_counter;

  match_controller #(.ROUNDS(ROUNDS), .RESULT_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
    .shot_valid(shot_valid), .shot_goal(shot_goal), .restart(restart),
    .game_state(game_state), .game_mode(game_mode),
    .round_counter(round_counter), .score(score), .opp_score(opp_score),
    .is_scored(is_scored)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mode;
    logic [3:0] rc;
    logic [2:0] sc;
    logic [2:0] opp;
    logic       scored;
  } exp_t;

  typedef struct packed {
    bit by_player;
    bit goal;
  } shot_t;

  exp_t  sb[$];
  int    tests = 0;
  int    fails = 0;
  int    seen_win = 0, seen_lose = 0;

  // Reference model: phase 0=START 1=KEEPER 2=SHOOTER 3=WINNER 4=LOOSER
  int    m_phase;
  bit    m_mode;
  shot_t m_shots[$];
  int    m_hold_left;
  bit    m_shown;

  function automatic void tally(output int ps, output int pg,
                                output int os, output int og);
    ps = 0; pg = 0; os = 0; og = 0;
    foreach (m_shots[i]) begin
      if (m_shots[i].by_player) begin ps++; pg += int'(m_shots[i].goal); end
      else begin os++; og += int'(m_shots[i].goal); end
    end
  endfunction

  function automatic void clear_match();
    m_shots.delete();
    m_hold_left = 0;
    m_shown = 1'b0;
  endfunction

  function automatic void model_step(bit r, bit st, bit mi, bit sv, bit sg, bit rs);
    int ps, pg, os, og;
    if (r) begin
      m_phase = 0; m_mode = 1'b1; clear_match();
      return;
    end
    case (m_phase)
      0: if (st) begin m_mode = mi; clear_match(); m_phase = 2; end
      1, 2: begin
        if (rs) begin clear_match(); m_phase = 0; end
        else if (m_hold_left > 0) begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            m_shown = 1'b0;
            tally(ps, pg, os, og);
            if (pg > og + (HALF - os))      m_phase = 3;
            else if (og >= pg + (HALF - ps)) m_phase = 4;
            else                             m_phase = (m_phase == 2) ? 1 : 2;
          end
        end else if (sv) begin
          m_shots.push_back('{by_player: (m_phase == 2), goal: sg});
          m_shown = sg;
          m_hold_left = HOLD;
        end
      end
      default: if (rs) begin clear_match(); m_phase = 0; end
    endcase
  endfunction

  function automatic exp_t model_out();
    int ps, pg, os, og;
    exp_t e;
    tally(ps, pg, os, og);
    e.st = 3'(m_phase); e.mode = m_mode; e.rc = 4'(m_shots.size());
    e.sc = 3'(pg); e.opp = 3'(og); e.scored = m_shown;
    return e;
  endfunction

  // Driver: new inputs on each falling edge, expected post-edge outputs queued.
  task automatic drive();
    int goal_pct = 50;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      rst        = (c < 2) || ($urandom_range(0, 599) == 0);
      start      = ($urandom_range(0, 4) == 0);
      mode_in    = $urandom_range(0, 1) == 1;
      shot_valid = ($urandom_range(0, 2) == 0);
      shot_goal  = ($urandom_range(0, 99) < goal_pct);
      restart    = ($urandom_range(0, 79) == 0);
      if (start) goal_pct = $urandom_range(10, 90);
      model_step(rst, start, mode_in, shot_valid, shot_goal, restart);
      sb.push_back(model_out());
    end
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  task automatic monitor();
    exp_t got, want;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty cycle=%0d", c);
      end else begin
        want = sb.pop_front();
        got  = '{st: game_state, mode: game_mode, rc: round_counter,
                 sc: score, opp: opp_score, scored: is_scored};
        if (want.st == 3'd3) seen_win++;
        if (want.st == 3'd4) seen_lose++;
        if (got !== want) begin
          fails++;
          $display("FAIL outputs cycle=%0d got st=%0d mode=%0d rc=%0d sc=%0d opp=%0d scored=%0d want st=%0d mode=%0d rc=%0d sc=%0d opp=%0d scored=%0d",
                   c, got.st, got.mode, got.rc, got.sc, got.opp, got.scored,
                   want.st, want.mode, want.rc, want.sc, want.opp, want.scored);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode_in = 1'b0;
    shot_valid = 1'b0; shot_goal = 1'b0; restart = 1'b0;
    m_phase = 0; m_mode = 1'b1; clear_match();
    fork
      drive();
      monitor();
    join
    tests++;
    if (seen_win == 0 || seen_lose == 0) begin
      fails++;
      $display("FAIL end_states_reached win_cycles=%0d lose_cycles=%0d required both>0",
               seen_win, seen_lose);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
